// File: rtl/chdr_16sc_to_8sc_pkg.sv
// Shared types, CHDR field constants and the sc16 -> sc8 component rounding helper.
package chdr_16sc_to_8sc_pkg;

    localparam int unsigned DATA_W       = 64;
    localparam int unsigned HALF_W       = 32;
    localparam int unsigned LEN_W        = 16;
    localparam int unsigned SID_W        = 32;
    localparam int unsigned DEST_W       = 16;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned SC16_W       = 32;
    localparam int unsigned SC8_W        = 16;
    localparam int unsigned COMP16_W     = 16;
    localparam int unsigned COMP8_W      = 8;
    localparam int unsigned SET_ADDR_W   = 8;
    localparam int unsigned SET_DATA_W   = 32;
    localparam int unsigned SID_EN_BIT   = 16;

    // Header byte counts with and without the timestamp line
    localparam logic [LEN_W-1:0] HDR_BYTES_NO_TIME = LEN_W'(8);
    localparam logic [LEN_W-1:0] HDR_BYTES_TIME    = LEN_W'(16);

    // CHDR header word: flags/seqnum [63:48] (has_time = bit 61), length [47:32], SID [31:0]
    typedef struct packed {
        logic [1:0]       pkt_type;
        logic             has_time;
        logic [12:0]      flags_seq;
        logic [LEN_W-1:0] len;
        logic [SID_W-1:0] sid;
    } chdr_hdr_t;

    // Encodings are visible on the debug port, so they are fixed
    typedef enum logic [STATE_W-1:0] {
        ST_HDR  = 3'd0,
        ST_TIME = 3'd1,
        ST_EVEN = 3'd2,
        ST_ODD  = 3'd3
    } state_t;

    // Round half-up to the upper byte of a signed 16-bit component, clamped to int8
    function automatic logic [COMP8_W-1:0] round_sat8(input logic [COMP16_W-1:0] x);
        logic [COMP16_W:0]       sum;
        logic signed [COMP8_W:0] q;
        sum = {x[COMP16_W-1], x} + 17'd128;
        q   = sum[COMP16_W:COMP8_W];
        if (q > 9'sd127) begin
            return 8'h7f;
        end else if (q < -9'sd128) begin
            return 8'h80;
        end else begin
            return q[COMP8_W-1:0];
        end
    endfunction

endpackage

// File: rtl/chdr_16sc_to_8sc_if.sv
// 64-bit CHDR stream with valid/ready handshake.
interface chdr_16sc_to_8sc_if;
    import chdr_16sc_to_8sc_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);

endinterface

// File: rtl/sc16_to_sc8_round_sat.sv
// Combinational sample converter: {I16,Q16} -> {I8,Q8} with rounding and saturation.
module sc16_to_sc8_round_sat
    import chdr_16sc_to_8sc_pkg::*;
(
    input  logic [SC16_W-1:0] sc16,
    output logic [SC8_W-1:0]  sc8_c
);

    // I in the upper half, Q in the lower half on both sides
    always_comb begin
        sc8_c = {round_sat8(sc16[SC16_W-1:COMP16_W]), round_sat8(sc16[COMP16_W-1:0])};
    end

endmodule

// File: rtl/chdr_16sc_to_8sc.sv
// CHDR sc16 -> sc8 packer: two payload lines in, one out; header length and optional SID rewrite.
module chdr_16sc_to_8sc
    import chdr_16sc_to_8sc_pkg::*;
#(
    parameter int unsigned BASE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_stb,
    input  logic [SET_ADDR_W-1:0] set_addr,
    input  logic [SET_DATA_W-1:0] set_data,
    chdr_16sc_to_8sc_if.slave     src,
    chdr_16sc_to_8sc_if.master    dst,
    output logic [SET_DATA_W-1:0] debug
);

    state_t              state_q;
    state_t              state_d;
    logic [HALF_W-1:0]   hold_q;
    logic [HALF_W-1:0]   hold_d;
    logic [CNT_W-1:0]    line_cnt_q;
    logic                sid_enable_q;
    logic [DEST_W-1:0]   dest_home_q;

    logic                accept_c;
    logic                emit_c;
    logic                last_c;
    logic [DATA_W-1:0]   data_c;
    logic [SC8_W-1:0]    conv_hi_c;
    logic [SC8_W-1:0]    conv_lo_c;
    chdr_hdr_t           hdr_in_c;
    chdr_hdr_t           hdr_out_c;
    logic [LEN_W-1:0]    hdr_bytes_c;
    logic [LEN_W-1:0]    payload_bytes_c;

    logic                unused_set_data;

    assign unused_set_data = ^set_data[SET_DATA_W-1:SID_EN_BIT+1];

    // A beat moves whenever the output register is empty or being drained
    assign src.tready = ~dst.tvalid | dst.tready;
    assign accept_c   = src.tvalid & src.tready;

    assign debug = {3'(state_q), 13'b0, line_cnt_q};

    sc16_to_sc8_round_sat u_conv_hi (
        .sc16  (src.tdata[DATA_W-1:HALF_W]),
        .sc8_c (conv_hi_c)
    );

    sc16_to_sc8_round_sat u_conv_lo (
        .sc16  (src.tdata[HALF_W-1:0]),
        .sc8_c (conv_lo_c)
    );

    // Settings register; only consulted when a header is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sid_enable_q <= 1'b0;
            dest_home_q  <= '0;
        end else if (set_stb && (set_addr == SET_ADDR_W'(BASE))) begin
            sid_enable_q <= set_data[SID_EN_BIT];
            dest_home_q  <= set_data[DEST_W-1:0];
        end
    end

    // Header rewrite: payload halves, header size kept, SID optionally re-homed
    always_comb begin
        hdr_in_c        = chdr_hdr_t'(src.tdata);
        hdr_out_c       = hdr_in_c;
        hdr_bytes_c     = hdr_in_c.has_time ? HDR_BYTES_TIME : HDR_BYTES_NO_TIME;
        payload_bytes_c = hdr_in_c.len - hdr_bytes_c;
        hdr_out_c.len   = hdr_bytes_c + (payload_bytes_c >> 1);
        if (sid_enable_q) begin
            hdr_out_c.sid = {hdr_in_c.sid[DEST_W-1:0], dest_home_q};
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pairing of payload lines and the beat to load into the output stage
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        emit_c  = 1'b0;
        last_c  = 1'b0;
        data_c  = '0;
        case (state_q)
            ST_HDR: begin
                if (accept_c) begin
                    emit_c = 1'b1;
                    data_c = DATA_W'(hdr_out_c);
                    last_c = src.tlast;
                    if (src.tlast) begin
                        state_d = ST_HDR;
                    end else if (hdr_in_c.has_time) begin
                        state_d = ST_TIME;
                    end else begin
                        state_d = ST_EVEN;
                    end
                end
            end
            ST_TIME: begin
                if (accept_c) begin
                    emit_c  = 1'b1;
                    data_c  = src.tdata;
                    last_c  = src.tlast;
                    state_d = src.tlast ? ST_HDR : ST_EVEN;
                end
            end
            ST_EVEN: begin
                if (accept_c) begin
                    hold_d = {conv_hi_c, conv_lo_c};
                    if (src.tlast) begin
                        emit_c  = 1'b1;
                        data_c  = {hold_d, HALF_W'(0)};
                        last_c  = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_ODD;
                    end
                end
            end
            ST_ODD: begin
                if (accept_c) begin
                    emit_c  = 1'b1;
                    data_c  = {hold_q, conv_hi_c, conv_lo_c};
                    last_c  = src.tlast;
                    state_d = src.tlast ? ST_HDR : ST_EVEN;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // First-of-pair converted samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Accepted-line counter, restarted by every header
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_cnt_q <= '0;
        end else if (accept_c) begin
            if (state_q == ST_HDR) begin
                line_cnt_q <= '0;
            end else begin
                line_cnt_q <= line_cnt_q + CNT_W'(1);
            end
        end
    end

    // Single output register stage; frozen while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst.tvalid <= 1'b0;
            dst.tlast  <= 1'b0;
            dst.tdata  <= '0;
        end else if (~dst.tvalid | dst.tready) begin
            dst.tvalid <= emit_c;
            if (emit_c) begin
                dst.tdata <= data_c;
                dst.tlast <= last_c;
            end
        end
    end

endmodule

// File: tb/tb_chdr_16sc_to_8sc.sv
// Directed-vector and randomised-backpressure bench for chdr_16sc_to_8sc.
module tb_chdr_16sc_to_8sc;

    localparam int unsigned BASE = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'h00;
    logic [31:0] set_data = 32'h0;
    logic [31:0] debug;

    logic        ready_mode = 1'b0;
    logic        ready_val = 1'b1;
    logic        rnd_bit = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] pkt_q[$];
    logic [63:0] exp_d[$];
    logic        exp_l[$];
    logic [63:0] got_d[$];
    logic        got_l[$];

    typedef struct {
        logic            sid_en;
        int              n_in;
        logic [7:0][63:0] in_d;
        int              n_out;
        logic [7:0][63:0] out_d;
    } vec_t;

    vec_t vecs[7];

    chdr_16sc_to_8sc_if in_if ();
    chdr_16sc_to_8sc_if out_if ();

    chdr_16sc_to_8sc #(.BASE(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .src      (in_if.slave),
        .dst      (out_if.master),
        .debug    (debug)
    );

    always #5 clk = ~clk;

    assign out_if.tready = ready_mode ? rnd_bit : ready_val;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Record every beat the consumer takes (inputs only change just after rising edges)
    always @(negedge clk) begin
        if (!reset && out_if.tvalid && out_if.tready) begin
            got_d.push_back(out_if.tdata);
            got_l.push_back(out_if.tlast);
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 timeouts", 1);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] m_conv(input logic [15:0] x);
        int v;
        v = int'($signed(x)) + 128;
        v = v >>> 8;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    function automatic logic [31:0] m_line(input logic [63:0] d);
        return {m_conv(d[63:48]), m_conv(d[47:32]), m_conv(d[31:16]), m_conv(d[15:0])};
    endfunction

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
    endtask

    task automatic send_line(input logic [63:0] d, input logic l);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        in_if.tdata = d;
        in_if.tlast = l;
        in_if.tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_if.tready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n++;
                if (n > 500) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL send_timeout: got no i_tready in %0d cycles, expected acceptance", n);
                    done = 1'b1;
                end
            end
        end
        in_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt();
        for (int k = 0; k < pkt_q.size(); k++) begin
            send_line(pkt_q[k], k == pkt_q.size() - 1);
        end
    endtask

    task automatic drain(input int tag);
        int n;
        int b;
        logic [63:0] gd;
        logic        gl;
        n = 0;
        b = 0;
        while (got_d.size() < exp_d.size() && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("beat_count_t%0d", tag), 64'(got_d.size()), 64'(exp_d.size()));
        while (exp_d.size() > 0 && got_d.size() > 0) begin
            gd = got_d.pop_front();
            gl = got_l.pop_front();
            chk($sformatf("data_t%0d_b%0d", tag, b), gd, exp_d[0]);
            chk($sformatf("last_t%0d_b%0d", tag, b), 64'(gl), 64'(exp_l[0]));
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            b++;
        end
        exp_d.delete();
        exp_l.delete();
        got_d.delete();
        got_l.delete();
    endtask

    initial begin
        in_if.tdata = '0;
        in_if.tlast = 1'b0;
        in_if.tvalid = 1'b0;

        // timestamped, SID rewrite, saturation, single odd line
        vecs[0].sid_en = 1'b1; vecs[0].n_in = 3; vecs[0].n_out = 3;
        vecs[0].in_d[0] = 64'h2000_0018_DEAD_BEEF;
        vecs[0].in_d[1] = 64'h0000_0001_2345_6789;
        vecs[0].in_d[2] = 64'h7FFF_8000_0080_0000;
        vecs[0].out_d[0] = 64'h2000_0014_BEEF_FEED;
        vecs[0].out_d[1] = 64'h0000_0001_2345_6789;
        vecs[0].out_d[2] = 64'h7F80_0100_0000_0000;
        // two lines pack into one
        vecs[1].sid_en = 1'b0; vecs[1].n_in = 3; vecs[1].n_out = 2;
        vecs[1].in_d[0] = 64'h0000_0018_0123_4567;
        vecs[1].in_d[1] = 64'h0100_0200_0300_0400;
        vecs[1].in_d[2] = 64'h0500_0600_0700_0800;
        vecs[1].out_d[0] = 64'h0000_0010_0123_4567;
        vecs[1].out_d[1] = 64'h0102_0304_0506_0708;
        // three lines, zero-padded tail
        vecs[2].sid_en = 1'b0; vecs[2].n_in = 4; vecs[2].n_out = 3;
        vecs[2].in_d[0] = 64'h1000_0014_0000_0001;
        vecs[2].in_d[1] = 64'h0100_0200_0300_0400;
        vecs[2].in_d[2] = 64'h0500_0600_0700_0800;
        vecs[2].in_d[3] = 64'h0900_0A00_0B00_0C00;
        vecs[2].out_d[0] = 64'h1000_000E_0000_0001;
        vecs[2].out_d[1] = 64'h0102_0304_0506_0708;
        vecs[2].out_d[2] = 64'h090A_0B0C_0000_0000;
        // header-only
        vecs[3].sid_en = 1'b0; vecs[3].n_in = 1; vecs[3].n_out = 1;
        vecs[3].in_d[0] = 64'h0000_0008_AAAA_5555;
        vecs[3].out_d[0] = 64'h0000_0008_AAAA_5555;
        // header-only with SID rewrite
        vecs[4].sid_en = 1'b1; vecs[4].n_in = 1; vecs[4].n_out = 1;
        vecs[4].in_d[0] = 64'h0000_0008_AAAA_5555;
        vecs[4].out_d[0] = 64'h0000_0008_5555_FEED;
        // negative rounding and positive saturation
        vecs[5].sid_en = 1'b0; vecs[5].n_in = 3; vecs[5].n_out = 2;
        vecs[5].in_d[0] = 64'h1234_0018_0000_1234;
        vecs[5].in_d[1] = 64'hFF7F_FF80_7F80_8080;
        vecs[5].in_d[2] = 64'h0000_0000_00FF_FF00;
        vecs[5].out_d[0] = 64'h1234_0010_0000_1234;
        vecs[5].out_d[1] = 64'hFF00_7F81_0000_01FF;
        // timestamped, even number of payload lines
        vecs[6].sid_en = 1'b0; vecs[6].n_in = 4; vecs[6].n_out = 3;
        vecs[6].in_d[0] = 64'h2000_0020_0000_0042;
        vecs[6].in_d[1] = 64'h0000_0000_0000_0100;
        vecs[6].in_d[2] = 64'h0000_0100_FF00_FEFF;
        vecs[6].in_d[3] = 64'h7F7F_0080_FF80_0000;
        vecs[6].out_d[0] = 64'h2000_0018_0000_0042;
        vecs[6].out_d[1] = 64'h0000_0000_0000_0100;
        vecs[6].out_d[2] = 64'h0001_FFFF_7F01_0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("rst_o_tlast", 64'(out_if.tlast), 64'd0);
        chk("rst_o_tdata", out_if.tdata, 64'd0);
        chk("rst_debug", 64'(debug), 64'd0);
        chk("rst_i_tready", 64'(in_if.tready), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            set_reg(8'(BASE), {15'd0, vecs[v].sid_en, 16'hFEED});
            set_reg(8'h01, {15'd0, ~vecs[v].sid_en, 16'h1111});
            pkt_q.delete();
            for (int k = 0; k < vecs[v].n_in; k++) pkt_q.push_back(vecs[v].in_d[k]);
            for (int k = 0; k < vecs[v].n_out; k++) begin
                exp_d.push_back(vecs[v].out_d[k]);
                exp_l.push_back(k == vecs[v].n_out - 1);
            end
            send_pkt();
            drain(v);
        end

        // back-to-back packets with 50% consumer backpressure against the bench model
        ready_mode = 1'b1;
        for (int p = 0; p < 8; p++) begin
            int          n;
            int          hb;
            logic        ht;
            logic        sen;
            logic [63:0] h;
            logic [63:0] t;
            logic [63:0] pl[$];
            n = $urandom_range(2, 16);
            ht = 1'($urandom_range(0, 1));
            sen = 1'($urandom_range(0, 1));
            hb = ht ? 16 : 8;
            set_reg(8'(BASE), {15'd0, sen, 16'hC0DE});
            h = {2'b01, ht, 13'($urandom), 16'(hb + 8 * n), $urandom};
            pkt_q.delete();
            pkt_q.push_back(h);
            exp_d.push_back({h[63:48], 16'(hb + 4 * n), sen ? {h[15:0], 16'hC0DE} : h[31:0]});
            exp_l.push_back(1'b0);
            if (ht) begin
                t = {$urandom, $urandom};
                pkt_q.push_back(t);
                exp_d.push_back(t);
                exp_l.push_back(1'b0);
            end
            pl.delete();
            for (int k = 0; k < n; k++) begin
                if (k == 0) pl.push_back(64'h7FFF_8000_7F80_807F);
                else pl.push_back({$urandom, $urandom});
                pkt_q.push_back(pl[k]);
            end
            for (int k = 0; k < n; k += 2) begin
                exp_d.push_back({m_line(pl[k]), (k + 1 < n) ? m_line(pl[k + 1]) : 32'h0});
                exp_l.push_back(k + 2 >= n);
            end
            send_pkt();
        end
        drain(100);
        ready_mode = 1'b0;
        ready_val = 1'b1;

        // reset while the output stage is stalled mid-packet
        set_reg(8'(BASE), 32'h0);
        send_line(64'h0000_0018_0000_0077, 1'b0);
        exp_d.push_back(64'h0000_0010_0000_0077);
        exp_l.push_back(1'b0);
        send_line(64'h7FFF_7FFF_8000_8000, 1'b0);
        chk("odd_state", 64'(debug[31:29]), 64'd3);
        ready_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_line(64'h0100_0200_0300_0400, 1'b0);
        in_if.tdata = 64'h0500_0600_0700_0800;
        in_if.tlast = 1'b1;
        in_if.tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_i_tready", 64'(in_if.tready), 64'd0);
        chk("stall_o_tvalid", 64'(out_if.tvalid), 64'd1);
        chk("stall_o_tdata", out_if.tdata, 64'h7F7F_8080_0102_0304);
        @(posedge clk);
        #1;
        chk("stall_o_tdata_frozen", out_if.tdata, 64'h7F7F_8080_0102_0304);
        chk("stall_o_tlast", 64'(out_if.tlast), 64'd0);
        reset = 1'b1;
        #1;
        chk("midrst_o_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("midrst_debug", 64'(debug), 64'd0);
        in_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_val = 1'b1;
        pkt_q.delete();
        for (int k = 0; k < vecs[2].n_in; k++) pkt_q.push_back(vecs[2].in_d[k]);
        for (int k = 0; k < vecs[2].n_out; k++) begin
            exp_d.push_back(vecs[2].out_d[k]);
            exp_l.push_back(k == vecs[2].n_out - 1);
        end
        send_pkt();
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
